// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - request FIFO and in-order issue master for a 16x16 single-port memory
module mem_req_ctrl #(
  parameter int Depth      = 4,
  parameter int Data_width = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [Depth-1:0]      req_addr,
  input  logic [Data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [Data_width-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  EN,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [Depth-1:0]      add,
  output logic [Data_width-1:0] Data_in,
  input  logic                  valid_out,
  input  logic [Data_width-1:0] Data_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + Depth + Data_width;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t                  state, state_next;
  logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop, load;
  logic                    head_write;
  logic [Depth-1:0]        head_addr;
  logic [Data_width-1:0]   head_wdata;
  logic [TW-1:0]           tmr;
  logic                    tmr_clr, tmr_inc, tmr_done;
  logic                    rsp_ok, rsp_to;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // Ready comes only from the registered count, so a same-cycle pop never frees a full FIFO.
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr];
  assign tmr_done   = (tmr == TW'(TIMEOUT - 1));
  assign busy       = (count != '0) || (state != IDLE);

  // Request storage; entries are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next state; rd_en tells ISSUE whether the access in flight is a read.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE: begin
        if (rd_en)           state_next = WAIT_RD;
        else if (fifo_empty) state_next = IDLE;
      end
      WAIT_RD: if (valid_out || tmr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM control decode: FIFO pops, pin loads, timer control and response events.
  always_comb begin
    pop     = 1'b0;
    load    = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    rsp_ok  = 1'b0;
    rsp_to  = 1'b0;
    case (state)
      IDLE: begin
        pop  = !fifo_empty;
        load = !fifo_empty;
      end
      ISSUE: begin
        if (rd_en) begin
          tmr_clr = 1'b1;
        end else begin
          pop  = !fifo_empty;
          load = !fifo_empty;
        end
      end
      WAIT_RD: begin
        if (valid_out)     rsp_ok  = 1'b1;
        else if (tmr_done) rsp_to  = 1'b1;
        else               tmr_inc = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered memory pins; strobes last one cycle, address and data hold between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      EN      <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      add     <= '0;
      Data_in <= '0;
    end else if (load) begin
      EN      <= 1'b1;
      wr_en   <= head_write;
      rd_en   <= !head_write;
      add     <= head_addr;
      Data_in <= head_wdata;
    end else begin
      EN    <= 1'b0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end
  end

  // Read-timeout counter, restarted as each read strobe retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         tmr <= '0;
    else if (tmr_clr) tmr <= '0;
    else if (tmr_inc) tmr <= tmr + TW'(1);
  end

  // Response strobe; data and error flag hold until the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_ok || rsp_to;
      if (rsp_ok) begin
        rsp_rdata <= Data_out;
        rsp_err   <= 1'b0;
      end else if (rsp_to) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Upstream request master for the 16x16 single-port memory. It owns the memory's EN/wr_en/rd_en/add/Data_in pins and consumes valid_out/Data_out.
- Accepts read/write requests from a client over a valid/ready handshake and buffers them in a small FIFO.
- Issues requests to the memory in order and returns read data, or a timeout error, on a one-cycle response strobe.

Parameters:
- Depth, 4, memory address width in bits (16 locations)
- Data_width, 32, data width in bits
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, at least 2
- TIMEOUT, 8, cycles to wait for valid_out after a read strobe before flagging an error; at least 1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  client request present
- req_ready  out  1  FIFO can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  Depth  request address
- req_wdata  in  Data_width  write data; ignored for reads
- rsp_valid  out  1  one-cycle read-completion strobe
- rsp_rdata  out  Data_width  read data; 0 on error
- rsp_err  out  1  qualifies rsp_valid; 1 = read timed out
- busy  out  1  FIFO non-empty or FSM not IDLE
- EN  out  1  memory enable
- wr_en  out  1  memory write strobe
- rd_en  out  1  memory read strobe
- add  out  Depth  memory address
- Data_in  out  Data_width  memory write data
- valid_out  in  1  memory read-data valid
- Data_out  in  Data_width  memory read data

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO flushed; FSM goes to IDLE; timeout counter cleared.
  - All outputs 0 except req_ready, which is 1.
  - A read in flight is dropped and produces no response.
- Handshake:
  - req_ready = !fifo_full, taken from registered FIFO state only.
  - A push occurs when req_valid && req_ready at a clk edge.
  - A full FIFO refuses the push even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full is legal and leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- All memory-side outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD.
  - IDLE: if the FIFO is non-empty, pop the head and load EN/wr_en/rd_en/add/Data_in; go to ISSUE.
  - ISSUE (strobe visible for exactly one cycle):
    - Write: if the FIFO is non-empty, pop and load the next request and stay in ISSUE (back-to-back, one memory access per cycle). Otherwise deassert the strobes and go to IDLE.
    - Read: deassert the strobes, clear the timeout counter, go to WAIT_RD.
  - WAIT_RD:
    - valid_out=1: register Data_out into rsp_rdata, pulse rsp_valid=1 with rsp_err=0, go to IDLE.
    - Counter reaches TIMEOUT-1 without valid_out: pulse rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
    - Otherwise increment the counter.
    - Later requests stay queued; there is no read/write reordering.
- Latency:
  - A request pushed at edge k into an empty FIFO with the FSM in IDLE drives the memory pins from edge k+1 to edge k+2.
  - Read response: rsp_valid rises one edge after the edge at which valid_out is sampled high.
- Idle values:
  - When not in ISSUE, EN/wr_en/rd_en = 0. add and Data_in hold their last values.
  - rsp_valid = 0 except for its one-cycle pulse; rsp_rdata and rsp_err hold until the next response.
- valid_out sampled high outside WAIT_RD is ignored.
- Writes produce no response.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Reset check: hold rst=0 mid-run -> all outputs 0, req_ready=1, busy=0 immediately (asynchronous).
- Write then read: write addr 4'h3 = 32'hDEADBEEF, then read addr 4'h3; memory model returns valid_out 2 cycles after rd_en -> one write strobe with add=3, Data_in=DEADBEEF; then rsp_valid pulse with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Back-to-back writes: 4 writes to addr 0..3 pushed on consecutive cycles -> wr_en high for 4 consecutive cycles, add=0,1,2,3; no rsp_valid.
- Full FIFO: stall the FSM in WAIT_RD (memory silent) and push FIFO_DEPTH requests -> req_ready=0 after the 4th push; the 5th req_valid is not accepted until a pop.
- Timeout: read with valid_out never asserted -> rsp_valid=1, rsp_err=1, rsp_rdata=0 exactly TIMEOUT cycles after entering WAIT_RD; the queued next request then issues.
- Reset in WAIT_RD: assert rst during a pending read, release, then drive valid_out=1 -> no rsp_valid; FIFO empty; busy=0.
